// File: rtl/db_arbiter_pkg.sv
// Shared encodings for the CPU data bus arbiter: access types, lengths, FSM states
// and the abort data word.
package db_arbiter_pkg;

  localparam int MEM_ACCESS_W = 2;
  localparam int MEM_LEN_W    = 2;

  typedef enum logic [MEM_ACCESS_W-1:0] {
    MEM_NONE = 2'd0,
    MEM_R    = 2'd1,
    MEM_W    = 2'd2,
    MEM_X    = 2'd3
  } mem_access_e;

  typedef enum logic [MEM_LEN_W-1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_W = 2'd2
  } mem_len_e;

  typedef enum logic [1:0] {
    DB_ARB_IDLE = 2'd0,
    DB_ARB_BUSY = 2'd1,
    DB_ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] DB_ARB_ABORT_DATA = 32'hDEAD_BEEF;

  // One bus request as seen by the slave.
  typedef struct packed {
    logic [31:0]             addr;
    logic [31:0]             data;
    logic [MEM_ACCESS_W-1:0] acc;
    logic [MEM_LEN_W-1:0]    len;
  } db_req_t;

  function automatic logic is_req(input logic [MEM_ACCESS_W-1:0] acc);
    return acc != MEM_NONE;
  endfunction

endpackage

// File: rtl/db_rr_pick.sv
// Combinational two-way round-robin chooser; last names the master granted most
// recently, so the other one wins a tie.
module db_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/db_arbiter.sv
// Two-master to one-slave data bus arbiter, one outstanding transaction at a time.
// Optional abort on a stalled slave: define DB_ARB_TIMEOUT_EN.
//
// Handshake: a master requests by holding accessType != NONE with stable
// addr/data/len until its one-cycle ready pulse; dataIn is valid with that pulse
// and held afterwards. Toward the slave, s_accessType != NONE is the request and
// the slave accepts on an edge with s_ready=1; s_dataIn is valid the next cycle.
module db_arbiter
  import db_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [31:0]             m0_addr,
  input  logic [31:0]             m0_dataOut,
  input  logic [MEM_ACCESS_W-1:0] m0_accessType,
  input  logic [MEM_LEN_W-1:0]    m0_memLen,
  output logic [31:0]             m0_dataIn,
  output logic                    m0_ready,
  input  logic [31:0]             m1_addr,
  input  logic [31:0]             m1_dataOut,
  input  logic [MEM_ACCESS_W-1:0] m1_accessType,
  input  logic [MEM_LEN_W-1:0]    m1_memLen,
  output logic [31:0]             m1_dataIn,
  output logic                    m1_ready,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_dataOut,
  output logic [MEM_ACCESS_W-1:0] s_accessType,
  output logic [MEM_LEN_W-1:0]    s_memLen,
  input  logic [31:0]             s_dataIn,
  input  logic                    s_ready,
  output logic [1:0]              gnt,
  output logic                    err,
  output arb_state_e              dbg_state
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam db_req_t REQ_RESET = '{addr: 32'h0, data: 32'h0, acc: MEM_NONE, len: LEN_W};

  arb_state_e  state_q, state_d;
  db_req_t     m0_req, m1_req, pick_req, s_req_q;
  logic [1:0]  req, pick, gnt_q;
  logic        last_q;
  logic        abort_q;
  logic        do_grant, do_accept, do_abort, to_hit;
  logic [31:0] m0_data_q, m1_data_q, resp_data;

  assign m0_req = '{addr: m0_addr, data: m0_dataOut, acc: m0_accessType, len: m0_memLen};
  assign m1_req = '{addr: m1_addr, data: m1_dataOut, acc: m1_accessType, len: m1_memLen};
  assign req    = {is_req(m1_accessType), is_req(m0_accessType)};

  db_rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  assign pick_req = pick[1] ? m1_req : m0_req;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state_q <= DB_ARB_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_grant  = 1'b0;
    do_accept = 1'b0;
    do_abort  = 1'b0;
    case (state_q)
      DB_ARB_IDLE: begin
        if (|pick) begin
          do_grant = 1'b1;
          state_d  = DB_ARB_BUSY;
        end
      end
      DB_ARB_BUSY: begin
        if (s_ready) begin
          do_accept = 1'b1;
          state_d   = DB_ARB_RESP;
        end else if (to_hit) begin
          do_abort = 1'b1;
          state_d  = DB_ARB_RESP;
        end
      end
      DB_ARB_RESP: state_d = DB_ARB_IDLE;
      default:     state_d = DB_ARB_IDLE;
    endcase
  end

  // Request latch, owner, round-robin pointer and per-master returned data.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      s_req_q   <= REQ_RESET;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      abort_q   <= 1'b0;
      m0_data_q <= 32'h0;
      m1_data_q <= 32'h0;
    end else begin
      if (do_grant) begin
        s_req_q <= pick_req;
        gnt_q   <= pick;
      end
      if (do_accept || do_abort) s_req_q.acc <= MEM_NONE;
      if (do_abort) abort_q <= 1'b1;
      if (state_q == DB_ARB_RESP) begin
        gnt_q   <= 2'b00;
        last_q  <= gnt_q[1];
        abort_q <= 1'b0;
        if (gnt_q[0]) m0_data_q <= resp_data;
        if (gnt_q[1]) m1_data_q <= resp_data;
      end
    end
  end

  // Slave data arrives during RESP, so the owner sees it live with its ready pulse.
  assign resp_data = abort_q ? DB_ARB_ABORT_DATA : s_dataIn;
  assign m0_ready  = (state_q == DB_ARB_RESP) && gnt_q[0];
  assign m1_ready  = (state_q == DB_ARB_RESP) && gnt_q[1];
  assign m0_dataIn = m0_ready ? resp_data : m0_data_q;
  assign m1_dataIn = m1_ready ? resp_data : m1_data_q;

  assign s_addr       = s_req_q.addr;
  assign s_dataOut    = s_req_q.data;
  assign s_accessType = s_req_q.acc;
  assign s_memLen     = s_req_q.len;
  assign gnt          = gnt_q;
  assign dbg_state    = state_q;

`ifdef DB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res)                                            to_cnt_q <= '0;
    else if (do_grant)                                   to_cnt_q <= '0;
    else if (state_q == DB_ARB_BUSY && !s_ready && !to_hit) to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_hit = (state_q == DB_ARB_BUSY) && (to_cnt_q == TO_LIMIT);
  assign err    = (state_q == DB_ARB_RESP) && abort_q;
`else
  logic to_unused;
  assign to_unused = ^TO_LIMIT;
  assign to_hit    = 1'b0;
  assign err       = 1'b0;
`endif

  a_one_ready: assert property (@(posedge clk) disable iff (!res) !(m0_ready && m1_ready));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!res) $onehot0(gnt_q));
  a_busy_hold: assert property (@(posedge clk) disable iff (!res)
    (state_q == DB_ARB_BUSY && !s_ready && !to_hit) |=> (state_q == DB_ARB_BUSY && $stable(s_req_q)));

endmodule

// File: tb/tb_db_arbiter.sv
// Bench for db_arbiter: per-master drivers, a byte-wide big-endian slave memory
// model and a scoreboard of expected {err, master, data} responses.
module tb_db_arbiter;
  import db_arbiter_pkg::*;

`ifdef DB_ARB_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  typedef struct packed {
    logic [1:0]  acc;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [31:0] m0_addr, m0_dataOut, m0_dataIn, m1_addr, m1_dataOut, m1_dataIn;
  logic [1:0]  m0_accessType, m0_memLen, m1_accessType, m1_memLen;
  logic        m0_ready, m1_ready;
  logic [31:0] s_addr, s_dataOut, s_dataIn;
  logic [1:0]  s_accessType, s_memLen, gnt;
  logic        s_ready, err;
  arb_state_e  dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [33:0] exp_q[$];
  cmd_t        cmd_q0[$], cmd_q1[$];
  bit          busy[2];
  int          lat[2];
  logic [31:0] last_data[2];
  bit          drv_abort = 1'b0;
  logic [7:0]  mem [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  db_arbiter #(.TIMEOUT_CYCLES(TB_TO), .TO_W(8)) dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType),
    .m0_memLen(m0_memLen), .m0_dataIn(m0_dataIn), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType),
    .m1_memLen(m1_memLen), .m1_dataIn(m1_dataIn), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_dataOut(s_dataOut), .s_accessType(s_accessType),
    .s_memLen(s_memLen), .s_dataIn(s_dataIn), .s_ready(s_ready),
    .gnt(gnt), .err(err), .dbg_state(dbg_state)
  );

  // Slave: big-endian byte memory, read data valid the cycle after acceptance.
  logic [11:0] sa;
  assign sa = s_addr[11:0];
  always @(posedge clk or negedge res) begin
    if (!res) begin
      s_dataIn <= 32'h0;
    end else if (s_ready && s_accessType != MEM_NONE) begin
      if (s_accessType == MEM_W) begin
        case (s_memLen)
          LEN_B: mem[sa] = s_dataOut[7:0];
          LEN_H: begin mem[sa] = s_dataOut[15:8]; mem[sa+12'd1] = s_dataOut[7:0]; end
          default: begin
            mem[sa] = s_dataOut[31:24]; mem[sa+12'd1] = s_dataOut[23:16];
            mem[sa+12'd2] = s_dataOut[15:8]; mem[sa+12'd3] = s_dataOut[7:0];
          end
        endcase
        s_dataIn <= 32'h0;
      end else begin
        case (s_memLen)
          LEN_B:   s_dataIn <= {24'h0, mem[sa]};
          LEN_H:   s_dataIn <= {16'h0, mem[sa], mem[sa+12'd1]};
          default: s_dataIn <= {mem[sa], mem[sa+12'd1], mem[sa+12'd2], mem[sa+12'd3]};
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] acc, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] data);
    cmd_t c;
    c.acc = acc; c.len = len; c.addr = addr; c.data = data;
    return c;
  endfunction

  // Driver: present a request, hold it until the ready pulse, then drop it.
  task automatic run_cmd(input int m, input cmd_t c);
    int n;
    int t0;
    logic rdy;
    if (m == 0) begin
      m0_addr = c.addr; m0_dataOut = c.data; m0_memLen = c.len; m0_accessType = c.acc;
    end else begin
      m1_addr = c.addr; m1_dataOut = c.data; m1_memLen = c.len; m1_accessType = c.acc;
    end
    t0 = cyc;
    n = 0;
    rdy = 1'b0;
    while (n < 100 && !drv_abort && !rdy) begin
      @(negedge clk);
      n++;
      rdy = (m == 0) ? m0_ready : m1_ready;
    end
    if (rdy) lat[m] = cyc - t0;
    else if (!drv_abort) begin
      n_checks++;
      n_fail++;
      $display("FAIL drv_timeout_m%0d: no ready after %0d cycles, expected a ready pulse", m, n);
    end
    if (m == 0) m0_accessType = MEM_NONE;
    else        m1_accessType = MEM_NONE;
  endtask

  initial begin : drv0
    cmd_t c;
    m0_addr = 32'h0; m0_dataOut = 32'h0; m0_memLen = LEN_W; m0_accessType = MEM_NONE;
    forever begin
      @(negedge clk);
      if (res && cmd_q0.size() != 0) begin
        busy[0] = 1'b1;
        c = cmd_q0.pop_front();
        run_cmd(0, c);
        busy[0] = 1'b0;
      end
    end
  end

  initial begin : drv1
    cmd_t c;
    m1_addr = 32'h0; m1_dataOut = 32'h0; m1_memLen = LEN_W; m1_accessType = MEM_NONE;
    forever begin
      @(negedge clk);
      if (res && cmd_q1.size() != 0) begin
        busy[1] = 1'b1;
        c = cmd_q1.pop_front();
        run_cmd(1, c);
        busy[1] = 1'b0;
      end
    end
  end

  // Monitor: every ready pulse pops one expected {err, master, data} entry.
  initial begin : monitor
    logic [33:0] e;
    int m;
    forever begin
      @(negedge clk);
      if (res && (m0_ready || m1_ready)) begin
        check("single_ready", {m0_ready, m1_ready} == 2'b11, 1'b0);
        m = m1_ready ? 1 : 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: m%0d ready with data %0h, expected no response", m,
                   m ? m1_dataIn : m0_dataIn);
        end else begin
          e = exp_q.pop_front();
          check("resp_master", m, e[32]);
          check("resp_data", m ? m1_dataIn : m0_dataIn, e[31:0]);
          check("resp_err", err, e[33]);
          check("other_data", m ? m0_dataIn : m1_dataIn, last_data[1-m]);
          last_data[m] = e[31:0];
        end
      end else if (res && err) begin
        n_checks++;
        n_fail++;
        $display("FAIL err_without_ready: err=1, expected 0");
      end
    end
  end

  task automatic check_reset_values();
    check("rst_gnt", gnt, 2'b00);
    check("rst_state", dbg_state, DB_ARB_IDLE);
    check("rst_s_acc", s_accessType, MEM_NONE);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_dataOut", s_dataOut, 32'h0);
    check("rst_s_memLen", s_memLen, LEN_W);
    check("rst_m0_ready", m0_ready, 1'b0);
    check("rst_m1_ready", m1_ready, 1'b0);
    check("rst_m0_dataIn", m0_dataIn, 32'h0);
    check("rst_m1_dataIn", m1_dataIn, 32'h0);
    check("rst_err", err, 1'b0);
  endtask

  task automatic do_reset();
    res = 1'b0;
    last_data[0] = 32'h0;
    last_data[1] = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_values();
    res = 1'b1;
  endtask

  task automatic wait_gnt(input logic [1:0] g);
    int n = 0;
    while (gnt !== g && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_gnt", gnt, g);
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 300 && (cmd_q0.size() != 0 || cmd_q1.size() != 0 || busy[0] || busy[1] ||
                       exp_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() + cmd_q0.size() + cmd_q1.size(), 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]} = 32'h11223344;
    {mem[12'h104], mem[12'h105], mem[12'h106], mem[12'h107]} = 32'hA5A55A5A;
    {mem[12'h000], mem[12'h001], mem[12'h002], mem[12'h003]} = 32'hCAFEF00D;
    s_ready = 1'b1;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    do_reset();

    // Single read from m0: latency and slave-side view.
    @(posedge clk);
    exp_q.push_back({1'b0, 1'b0, 32'h11223344});
    cmd_q0.push_back(mk(MEM_R, LEN_W, 32'h100, 32'h0));
    wait_gnt(2'b01);
    check("t1_s_addr", s_addr, 32'h100);
    check("t1_s_acc", s_accessType, MEM_R);
    check("t1_s_len", s_memLen, LEN_W);
    check("t1_state_busy", dbg_state, DB_ARB_BUSY);
    @(negedge clk);
    check("t1_state_resp", dbg_state, DB_ARB_RESP);
    check("t1_m0_ready", m0_ready, 1'b1);
    check("t1_s_acc_none", s_accessType, MEM_NONE);
    check("t1_gnt_resp", gnt, 2'b01);
    wait_done();
    check("t1_latency", lat[0], 2);
    check("t1_gnt_idle", gnt, 2'b00);
    check("t1_m0_data_held", m0_dataIn, 32'h11223344);

    // Simultaneous continuous requests after reset: grants alternate 0,1,0,1.
    do_reset();
    @(posedge clk);
    exp_q.push_back({1'b0, 1'b0, 32'h11223344});
    exp_q.push_back({1'b0, 1'b1, 32'h00003344});
    exp_q.push_back({1'b0, 1'b0, 32'h00000022});
    exp_q.push_back({1'b0, 1'b1, 32'hA5A55A5A});
    cmd_q0.push_back(mk(MEM_R, LEN_W, 32'h100, 32'h0));
    cmd_q0.push_back(mk(MEM_R, LEN_B, 32'h101, 32'h0));
    cmd_q1.push_back(mk(MEM_R, LEN_H, 32'h102, 32'h0));
    cmd_q1.push_back(mk(MEM_R, LEN_W, 32'h104, 32'h0));
    wait_done();

    // m1 half-word write, then m0 instruction fetch queued behind it.
    @(posedge clk);
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    exp_q.push_back({1'b0, 1'b0, 32'hCAFEF00D});
    cmd_q1.push_back(mk(MEM_W, LEN_H, 32'h200, 32'h0000BEEF));
    wait_gnt(2'b10);
    check("t3_s_dataOut", s_dataOut, 32'h0000BEEF);
    check("t3_s_addr", s_addr, 32'h200);
    check("t3_s_acc", s_accessType, MEM_W);
    check("t3_s_len", s_memLen, LEN_H);
    cmd_q0.push_back(mk(MEM_X, LEN_W, 32'h0, 32'h0));
    wait_done();
    check("t3_mem200", mem[12'h200], 8'hBE);
    check("t3_mem201", mem[12'h201], 8'hEF);

`ifndef DB_ARB_TIMEOUT_EN
    // Slave stalls for 5 BUSY cycles; request stays frozen.
    @(posedge clk);
    s_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'h11223344});
    cmd_q0.push_back(mk(MEM_R, LEN_W, 32'h100, 32'h0));
    wait_gnt(2'b01);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_addr", s_addr, 32'h100);
      check("t4_hold_acc", s_accessType, MEM_R);
      check("t4_hold_len", s_memLen, LEN_W);
      check("t4_hold_state", dbg_state, DB_ARB_BUSY);
      check("t4_no_ready", m0_ready, 1'b0);
      @(negedge clk);
    end
    s_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_after_accept", m0_ready, 1'b1);
    wait_done();
`else
    // Slave never accepts: abort with err and the abort data word.
    @(posedge clk);
    s_ready = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    cmd_q0.push_back(mk(MEM_R, LEN_W, 32'h100, 32'h0));
    wait_done();
    check("t5_state_idle", dbg_state, DB_ARB_IDLE);
    check("t5_m0_data_held", m0_dataIn, 32'hDEADBEEF);
    check("t5_s_acc_none", s_accessType, MEM_NONE);
    s_ready = 1'b1;
`endif

    // Asynchronous reset in the middle of a BUSY transaction.
    @(posedge clk);
    s_ready = 1'b0;
    cmd_q1.push_back(mk(MEM_R, LEN_W, 32'h104, 32'h0));
    wait_gnt(2'b10);
    @(negedge clk);
    #2;
    res = 1'b0;
    last_data[0] = 32'h0;
    last_data[1] = 32'h0;
    #1;
    check_reset_values();
    drv_abort = 1'b1;
    repeat (3) @(negedge clk);
    drv_abort = 1'b0;
    s_ready = 1'b1;
    res = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_idle_after_reset", dbg_state, DB_ARB_IDLE);
    check("t6_m1_data_clear", m1_dataIn, 32'h0);
    wait_done();

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU data bus.
- Master 0 is CPUCore; master 1 is a secondary requester (loader/DMA/debug port). The slave is the memory/MMIO side, e.g. the dummy memory model or the MMU.
- Round-robin grant with exactly one outstanding transaction. The request is latched and held stable toward the slave, and each master gets a one-cycle ready pulse with the returned data.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without slave ready before abort (only with DB_ARB_TIMEOUT_EN).
- TO_W, 8: width of the timeout counter; TIMEOUT_CYCLES must be < 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, asynchronous, active-low (asserted when 0).
- m0_addr, m0_dataOut  in  32 each  master 0 address and write data.
- m0_accessType  in  `MEM_ACCESS  NONE/R/W/X; non-NONE means request.
- m0_memLen  in  `MEM_LEN  B/H/W.
- m0_dataIn  out  32  read data returned to master 0.
- m0_ready  out  1  one-cycle completion pulse to master 0.
- m1_addr, m1_dataOut, m1_accessType, m1_memLen, m1_dataIn, m1_ready: same as master 0, for master 1.
- s_addr, s_dataOut  out  32 each  latched request toward the slave.
- s_accessType  out  `MEM_ACCESS  slave access type; NONE when idle.
- s_memLen  out  `MEM_LEN  slave access length.
- s_dataIn  in  32  slave read data, valid the cycle after acceptance.
- s_ready  in  1  slave accepts the presented request at this edge.
- gnt  out  2  one-hot owner of the current transaction; 0 when idle.
- err  out  1  one-cycle abort pulse (timeout).

Behaviour:
- Reset (res=0, async):
  - State IDLE, gnt=0, m*_ready=0, m*_dataIn=0, err=0.
  - s_accessType=NONE, s_addr=0, s_dataOut=0, s_memLen=W.
  - Round-robin pointer set so master 0 wins the first tie.
  - Reset mid-transaction discards it with no ready pulse.
- State IDLE:
  - A master requests when its accessType != NONE.
  - Exactly one requester: grant it.
  - Both requesting: grant the one not granted last.
  - On grant, register that master's addr/dataOut/accessType/memLen into s_*, set gnt, go to BUSY.
- State BUSY:
  - s_* held constant.
  - On an edge with s_ready=1, s_accessType goes to NONE and the state goes to RESP.
  - Master inputs are ignored in BUSY; a master must hold its request until its ready pulse.
- State RESP (exactly 1 cycle):
  - Owner's m_dataIn <= s_dataIn, captured for R, X and W.
  - Owner's m_ready=1 for this cycle only.
  - Round-robin pointer updated to the owner, gnt cleared, next state IDLE.
  - The non-owner's m_dataIn is unchanged.
- Latency: request present at edge N, s_ready constantly 1:
  - Slave sees the request after N.
  - Slave accepts at N+1.
  - m_ready is high in the cycle after N+1.
  - Back-to-back from one master: at most one request every 3 cycles.
- Fairness: both masters requesting continuously alternate grants, so no starvation.
- After a ready pulse, the master's next request is evaluated at the RESP->IDLE edge and must not be presented earlier.
- Writes to MMIO command addresses pass through unchanged; the arbiter does not decode addresses.
- m0 and m1 never both see ready in the same cycle.

Optional Feature:
- Macro DB_ARB_TIMEOUT_EN.
- With the macro:
  - BUSY counts cycles; the counter resets to 0 on entry.
  - If the count reaches TIMEOUT_CYCLES with s_ready still 0: s_accessType=NONE, go to RESP.
  - In that RESP: owner's m_dataIn=32'hDEADBEEF, m_ready pulses, err pulses concurrently.
- Without the macro: BUSY waits indefinitely and err is tied 0.

Decomposition:
- DataBus.vh holds:
  - MEM_ACCESS and MEM_LEN widths and encodings (NONE/R/W/X; B/H/W).
  - Arbiter state encodings DB_ARB_IDLE/BUSY/RESP.
  - Abort data constant DB_ARB_ABORT_DATA.
- One sub-module, db_rr_pick: combinational 2-way round-robin chooser.
  - Inputs: req[1:0], last[0].
  - Output: one-hot pick[1:0].

Test Plan:
- m0 reads W at 0x100 (mem=0x11223344), s_ready=1 -> s_addr=0x100 for one accept; m0_ready pulses once in the 3rd cycle after request; m0_dataIn=0x11223344; gnt=01 while active.
- m0 and m1 request at the same edge after reset -> m0 served first, then m1. Continuous requests -> grant order 0,1,0,1 over 4 transactions; never both ready in the same cycle.
- m1 writes H 0xBEEF to 0x200 while m0 requests X at 0x0 -> memory[0x200..0x201]=BE EF; then m0 gets its fetch word.
- s_ready held 0 for 5 cycles in BUSY -> s_* stable for all 5 cycles; ready pulse 1 cycle after s_ready rises.
- res=0 asserted mid-BUSY -> outputs return to reset values immediately (async); no m_ready pulse afterwards.
- With DB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, s_ready=0 forever -> err and m0_ready pulse together; m0_dataIn=0xDEADBEEF; state returns to IDLE.
